// File: rtl/agc_stat_accumulator_if.sv
// Bus between the saturate/scale stage, the AGC stat accumulator and the AGC control logic.
// The accumulator uses the slave modport, and its driver uses the master modport.
interface agc_stat_accumulator_if #(
    parameter int NSAMP       = 8,
    parameter int PERIOD_BITS = 24,
    parameter int COUNT_BITS  = 24,
    parameter int SQ_BITS     = 36
);
    logic [NSAMP-1:0]       gt_i;
    logic [NSAMP-1:0]       lt_i;
    logic [4*NSAMP-1:0]     abs_i;
    logic [PERIOD_BITS-1:0] period_i;
    logic                   start_i;
    logic                   busy_o;
    logic                   done_o;
    logic [COUNT_BITS-1:0]  gt_count_o;
    logic [COUNT_BITS-1:0]  lt_count_o;
    logic [SQ_BITS-1:0]     sumsq_o;

    modport master (
        output gt_i, lt_i, abs_i, period_i, start_i,
        input  busy_o, done_o, gt_count_o, lt_count_o, sumsq_o
    );

    modport slave (
        input  gt_i, lt_i, abs_i, period_i, start_i,
        output busy_o, done_o, gt_count_o, lt_count_o, sumsq_o
    );
endinterface

// File: rtl/agc_stat_accumulator.sv
// Windowed GT/LT count and sum-of-squares accumulator for the AGC loop.
// It uses a two-stage per-beat pipeline, and the accumulators saturate instead of wrapping.
module agc_stat_accumulator #(
    parameter int NSAMP       = 8,
    parameter int PERIOD_BITS = 24,
    parameter int COUNT_BITS  = 24,
    parameter int SQ_BITS     = 36
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    agc_stat_accumulator_if.slave  bus
);
    localparam int POP_BITS  = $clog2(NSAMP + 1);
    localparam int S1SQ_BITS = $clog2(225 * NSAMP + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [PERIOD_BITS-1:0] r_len;
    logic [PERIOD_BITS-1:0] r_beat;
    logic                   r_flush;

    logic [POP_BITS-1:0]    r_s1_gt, r_s1_lt;
    logic [S1SQ_BITS-1:0]   r_s1_sq;
    logic [COUNT_BITS-1:0]  r_gt_acc, r_lt_acc, r_gt_out, r_lt_out;
    logic [SQ_BITS-1:0]     r_sq_acc, r_sq_out;

    logic                   w_beat;
    logic [POP_BITS-1:0]    w_pop_gt, w_pop_lt;
    logic [S1SQ_BITS-1:0]   w_sq;
    logic [3:0]             w_abs;
    logic [7:0]             w_abs_sq;
    logic [COUNT_BITS:0]    w_gt_sum, w_lt_sum;
    logic [SQ_BITS:0]       w_sq_sum;
    logic [COUNT_BITS-1:0]  w_gt_next, w_lt_next;
    logic [SQ_BITS-1:0]     w_sq_next;

    assign w_beat = (r_state == ST_RUN);

    // A beat outside RUN is masked here, so stage 2 always adds zero for that beat.
    always_comb begin
        w_pop_gt = '0;
        w_pop_lt = '0;
        w_sq     = '0;
        w_abs    = '0;
        w_abs_sq = '0;
        for (int unsigned k = 0; k < NSAMP; k++) begin
            w_pop_gt = w_pop_gt + POP_BITS'(bus.gt_i[k] & w_beat);
            w_pop_lt = w_pop_lt + POP_BITS'(bus.lt_i[k] & w_beat);
            w_abs    = bus.abs_i[4*k +: 4];
            w_abs_sq = {4'b0000, w_abs} * {4'b0000, w_abs};
            if (w_beat) begin
                w_sq = w_sq + S1SQ_BITS'(w_abs_sq);
            end
        end
    end

    assign w_gt_sum  = {1'b0, r_gt_acc} + (COUNT_BITS+1)'(r_s1_gt);
    assign w_lt_sum  = {1'b0, r_lt_acc} + (COUNT_BITS+1)'(r_s1_lt);
    assign w_sq_sum  = {1'b0, r_sq_acc} + (SQ_BITS+1)'(r_s1_sq);
    assign w_gt_next = w_gt_sum[COUNT_BITS] ? '1 : w_gt_sum[COUNT_BITS-1:0];
    assign w_lt_next = w_lt_sum[COUNT_BITS] ? '1 : w_lt_sum[COUNT_BITS-1:0];
    assign w_sq_next = w_sq_sum[SQ_BITS]    ? '1 : w_sq_sum[SQ_BITS-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_beat   <= '0;
            r_flush  <= 1'b0;
            r_s1_gt  <= '0;
            r_s1_lt  <= '0;
            r_s1_sq  <= '0;
            r_gt_acc <= '0;
            r_lt_acc <= '0;
            r_sq_acc <= '0;
            r_gt_out <= '0;
            r_lt_out <= '0;
            r_sq_out <= '0;
        end else begin
            r_s1_gt  <= w_pop_gt;
            r_s1_lt  <= w_pop_lt;
            r_s1_sq  <= w_sq;
            r_gt_acc <= w_gt_next;
            r_lt_acc <= w_lt_next;
            r_sq_acc <= w_sq_next;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state  <= ST_RUN;
                        r_len    <= (bus.period_i == '0) ? PERIOD_BITS'(1) : bus.period_i;
                        r_beat   <= '0;
                        r_gt_acc <= '0;
                        r_lt_acc <= '0;
                        r_sq_acc <= '0;
                    end
                end
                ST_RUN: begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == r_len - 1'b1) begin
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b0;
                    end
                end
                // The first FLUSH cycle drains stage 1, and the second cycle sees the final sum.
                // The outputs load on the second cycle so they are valid together with done_o.
                ST_FLUSH: begin
                    r_flush <= 1'b1;
                    if (r_flush) begin
                        r_state  <= ST_DONE;
                        r_gt_out <= w_gt_next;
                        r_lt_out <= w_lt_next;
                        r_sq_out <= w_sq_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.done_o     = (r_state == ST_DONE);
    assign bus.gt_count_o = r_gt_out;
    assign bus.lt_count_o = r_lt_out;
    assign bus.sumsq_o    = r_sq_out;
endmodule

// File: tb/tb_agc_stat_accumulator.sv
// Directed bench for agc_stat_accumulator. It drives a full-width instance and a narrow instance
// (4-bit counters, 12-bit sum) with the same stimulus and checks both against a cycle-level window model.
module tb_agc_stat_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gt = '0, lt = '0;
    logic [31:0] absv = '0;
    logic [23:0] period = '0;
    logic        start = 1'b0;

    always #5 clk = ~clk;

    agc_stat_accumulator_if #(.NSAMP(8), .PERIOD_BITS(24), .COUNT_BITS(24), .SQ_BITS(36)) bus_m ();
    agc_stat_accumulator_if #(.NSAMP(8), .PERIOD_BITS(24), .COUNT_BITS(4),  .SQ_BITS(12)) bus_s ();

    assign bus_m.gt_i = gt;  assign bus_m.lt_i = lt;  assign bus_m.abs_i = absv;
    assign bus_m.period_i = period;  assign bus_m.start_i = start;
    assign bus_s.gt_i = gt;  assign bus_s.lt_i = lt;  assign bus_s.abs_i = absv;
    assign bus_s.period_i = period;  assign bus_s.start_i = start;

    agc_stat_accumulator #(.NSAMP(8), .PERIOD_BITS(24), .COUNT_BITS(24), .SQ_BITS(36)) u_dut_m (
        .clk_i(clk), .rst_i(rst), .bus(bus_m)
    );
    agc_stat_accumulator #(.NSAMP(8), .PERIOD_BITS(24), .COUNT_BITS(4), .SQ_BITS(12)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .bus(bus_s)
    );

    int checks = 0;
    int failures = 0;
    int n_done_m = 0;
    int n_done_s = 0;
    longint cyc = 0;

    // The model tracks each window by the cycle numbers of its start and its end.
    bit     m_valid = 0, m_active = 0;
    longint m_t = 0, m_n = 0, m_end = 0, m_gt = 0, m_lt = 0, m_sq = 0;
    bit     e_busy = 0, e_done = 0;
    longint e_gt_m = 0, e_lt_m = 0, e_sq_m = 0, e_gt_s = 0, e_lt_s = 0, e_sq_s = 0;

    function automatic longint sat(longint v, int bits);
        longint lim;
        lim = (longint'(1) << bits) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic longint sum_sq(logic [31:0] a);
        longint s, x;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            x = longint'(a[4*k +: 4]);
            s += x * x;
        end
        return s;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit acc;
        if (rst) begin
            m_active = 0;
            e_busy = 0; e_done = 0;
            e_gt_m = 0; e_lt_m = 0; e_sq_m = 0;
            e_gt_s = 0; e_lt_s = 0; e_sq_s = 0;
            m_valid = 1;
        end else begin
            acc = start && !m_active;
            if (m_active && cyc >= m_t + 1 && cyc <= m_t + m_n) begin
                m_gt += $countones(gt);
                m_lt += $countones(lt);
                m_sq += sum_sq(absv);
            end
            if (m_active && cyc == m_end) m_active = 0;
            if (acc) begin
                m_t = cyc;
                m_n = (period == 0) ? 1 : longint'(period);
                m_end = m_t + m_n + 3;
                m_gt = 0; m_lt = 0; m_sq = 0;
                m_active = 1;
            end
            e_busy = m_active;
            e_done = m_active && (cyc + 1 == m_end);
            if (e_done) begin
                e_gt_m = sat(m_gt, 24); e_lt_m = sat(m_lt, 24); e_sq_m = sat(m_sq, 36);
                e_gt_s = sat(m_gt, 4);  e_lt_s = sat(m_lt, 4);  e_sq_s = sat(m_sq, 12);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy_m", bus_m.busy_o, e_busy);
            chk("done_m", bus_m.done_o, e_done);
            chk("gt_m", bus_m.gt_count_o, e_gt_m);
            chk("lt_m", bus_m.lt_count_o, e_lt_m);
            chk("sq_m", bus_m.sumsq_o, e_sq_m);
            chk("busy_s", bus_s.busy_o, e_busy);
            chk("done_s", bus_s.done_o, e_done);
            chk("gt_s", bus_s.gt_count_o, e_gt_s);
            chk("lt_s", bus_s.lt_count_o, e_lt_s);
            chk("sq_s", bus_s.sumsq_o, e_sq_s);
            if (bus_m.done_o) n_done_m++;
            if (bus_s.done_o) n_done_s++;
        end
    end

    task automatic drive(bit s, int unsigned p, logic [7:0] g, logic [7:0] l, logic [31:0] a);
        @(negedge clk);
        start = s; period = p[23:0]; gt = g; lt = l; absv = a;
    endtask

    task automatic wait_done(string name, longint t0, longint lat);
        bit got;
        got = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus_m.done_o) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s done_o timeout actual=none expected=latency %0d", name, lat);
        end else begin
            chk({name, "_latency"}, cyc - t0, lat);
        end
    endtask

    task automatic check_res(string name, longint g, longint l, longint s,
                             longint gs, longint ls, longint ss);
        chk({name, "_gt_m"}, bus_m.gt_count_o, g);
        chk({name, "_lt_m"}, bus_m.lt_count_o, l);
        chk({name, "_sq_m"}, bus_m.sumsq_o, s);
        chk({name, "_gt_s"}, bus_s.gt_count_o, gs);
        chk({name, "_lt_s"}, bus_s.lt_count_o, ls);
        chk({name, "_sq_s"}, bus_s.sumsq_o, ss);
        chk({name, "_model_gt"}, e_gt_m, g);
        chk({name, "_model_sq"}, e_sq_m, s);
        chk({name, "_model_gt_s"}, e_gt_s, gs);
    endtask

    initial begin : stim
        longint t0;
        int nd;
        repeat (3) @(negedge clk);
        check_res("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_busy", bus_m.busy_o, 0);
        rst = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 32'h0);

        // 4 full-scale beats: 32 GT, sum 7200; the narrow copy saturates to 15 and 4095
        drive(1, 4, 8'hFF, 8'h00, 32'hFFFF_FFFF);
        t0 = cyc;
        repeat (4) drive(0, 4, 8'hFF, 8'h00, 32'hFFFF_FFFF);
        wait_done("win4", t0, 7);
        check_res("win4", 32, 0, 7200, 15, 0, 4095);

        // Garbage in the start cycle and in the cycle after the window must not count
        drive(1, 3, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
        t0 = cyc;
        drive(0, 0, 8'h0F, 8'h00, 32'h1111_1111);
        drive(0, 0, 8'h00, 8'hF0, 32'h1111_1111);
        drive(0, 0, 8'h0F, 8'h00, 32'h1111_1111);
        drive(0, 0, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
        wait_done("win3", t0, 6);
        check_res("win3", 8, 4, 24, 8, 4, 24);

        // period 0 behaves as a one-beat window
        drive(1, 0, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
        t0 = cyc;
        drive(0, 0, 8'h01, 8'h00, 32'h0000_0003);
        drive(0, 0, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
        wait_done("win0", t0, 4);
        check_res("win0", 1, 0, 9, 1, 0, 9);

        // Lanes with both flags set count in both counters; 24 saturates to 15 at 4 bits
        drive(1, 3, 8'hFF, 8'hFF, 32'h0);
        t0 = cyc;
        repeat (3) drive(0, 0, 8'hFF, 8'hFF, 32'h0);
        drive(0, 0, 8'h00, 8'h00, 32'h0);
        wait_done("sat", t0, 6);
        check_res("sat", 24, 24, 0, 15, 15, 0);

        // Reset at beat 50 of 100 aborts the window
        drive(1, 100, 8'h00, 8'h00, 32'h0);
        for (int i = 1; i < 50; i++) drive(0, 0, 8'(i), 8'(~i), {4{8'(i)}});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus_m.busy_o, 0);
        check_res("abort", 0, 0, 0, 0, 0, 0);
        #1 nd = n_done_m;
        repeat (110) drive(0, 0, 8'h00, 8'h00, 32'h0);
        #1 chk("abort_no_done", n_done_m, nd);

        // A new window after the abort starts from zero
        drive(1, 2, 8'h00, 8'h00, 32'h0);
        t0 = cyc;
        repeat (2) drive(0, 0, 8'h03, 8'h01, 32'h0000_0021);
        wait_done("post_abort", t0, 5);
        check_res("post_abort", 4, 2, 10, 4, 2, 10);

        // start pulses during RUN and on the done cycle are ignored
        #1 nd = n_done_m;
        drive(1, 5, 8'h00, 8'h00, 32'h0);
        t0 = cyc;
        drive(0, 0, 8'h01, 8'h02, 32'h0000_0002);
        drive(1, 1, 8'h01, 8'h02, 32'h0000_0002);
        repeat (3) drive(0, 0, 8'h01, 8'h02, 32'h0000_0002);
        drive(0, 0, 8'h00, 8'h00, 32'h0);
        wait_done("ign", t0, 8);
        start = 1'b1;
        period = 24'd1;
        gt = 8'hFF;
        repeat (20) drive(0, 0, 8'h00, 8'h00, 32'h0);
        check_res("ign", 5, 5, 20, 5, 5, 20);
        #1 chk("ign_one_done", n_done_m, nd + 1);
        chk("ign_busy", bus_m.busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
